// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

  // Controller states; the fourth encoding is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: enough bits to count 0..steps-1, never narrower than 1.
  function automatic int cnt_width(input int steps);
    if (steps <= 2) begin
      return 1;
    end
    return $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational ripple of DIGIT full-adder cells, one digit of the serial add.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             ctop
);

  // Ripple the carry LSB to MSB; the carry into the top cell is exported
  // because on the final digit it is the carry into the operand MSB.
  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[DIGIT];
    ctop = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract engine: WIDTH-bit operands, DIGIT bits per cycle, LSB first.
// Latency: accept on edge T, out_valid after edge T+STEPS; one op per STEPS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until return to IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // WIDTH must be >= 2 and an integer multiple of DIGIT.
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_step;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_ctop;

  adder_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout),
    .ctop (dig_ctop)
  );

  assign last_step = (cnt == CW'(STEPS - 1));

  // New digit enters at the MSB end so after STEPS shifts the result is aligned.
  assign sum_shift = (sum_r >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; DONE never overlaps with in_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept (subtract as a + ~b + 1), then shift
  // one digit per RUN cycle; result flags are captured only on the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      sum_r <= sum_shift;
      carry <= dig_cout;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        cout_r <= dig_cout;
        ovf_r  <= dig_ctop ^ dig_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder across three width/digit configurations.
// Latency: checks accept-to-out_valid equals STEPS for each configuration.
// Backpressure: holds out_ready low in DONE and checks result stability.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [2:0]  iv;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        co0, co1, co2;
  logic        of0, of1, of2;
  logic [7:0]  sum0;
  logic [15:0] sum1;
  logic [7:0]  sum2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .cout(co0), .overflow(of0)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .cout(co1), .overflow(of1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(sum2), .cout(co2), .overflow(of2)
  );

  function automatic int steps_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 4 : 1;
  endfunction

  function automatic int width_of(input int d);
    return (d == 1) ? 16 : 8;
  endfunction

  function automatic logic get_ir(input int d);
    return (d == 0) ? ir0 : (d == 1) ? ir1 : ir2;
  endfunction

  function automatic logic get_ov(input int d);
    return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
  endfunction

  function automatic logic [15:0] get_sum(input int d);
    return (d == 0) ? {8'h00, sum0} : (d == 1) ? sum1 : {8'h00, sum2};
  endfunction

  function automatic logic get_co(input int d);
    return (d == 0) ? co0 : (d == 1) ? co1 : co2;
  endfunction

  function automatic logic get_of(input int d);
    return (d == 0) ? of0 : (d == 1) ? of1 : of2;
  endfunction

  // Reference: plain integer add on masked operands, signed overflow from sign bits.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    logic [15:0] mask;
    logic [15:0] am;
    logic [15:0] bb;
    logic [16:0] full;
    exp_t        e;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    am     = a & mask;
    bb     = s ? (~b & mask) : (b & mask);
    full   = {1'b0, am} + {1'b0, bb} + (s ? 17'd1 : {16'd0, c});
    e.sum  = full[15:0] & mask;
    e.cout = full[w];
    e.ovf  = (am[w-1] == bb[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  // One operation on DUT d; hold > 0 keeps out_ready low that many cycles in DONE.
  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input int hold);
    int          k;
    bit          got;
    exp_t        e;
    logic [15:0] hs;
    logic        hc;
    logic        ho;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; sub = s;
    iv[d] = 1'b1;
    out_ready = (hold == 0);
    k = 0;
    while (!get_ir(d) && k < 40) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!get_ir(d)) begin
      fails++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b, required 1", d, get_ir(d));
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(width_of(d), a, b, c, s));
    k = 0;
    got = 1'b0;
    while (k < 40) begin
      @(negedge clk);
      if (k == 0) begin
        iv[d] = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        cin  = 1'($urandom);
        sub  = 1'($urandom);
      end
      if (get_ov(d)) begin
        got = 1'b1;
        break;
      end
      k++;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL result_timeout dut%0d: out_valid=0 after %0d cycles, required 1", d, k);
      void'(sb.pop_front());
      out_ready = 1'b1;
      return;
    end
    if (k != steps_of(d)) begin
      fails++;
      $display("FAIL latency dut%0d: %0d cycles, required %0d", d, k, steps_of(d));
    end
    e = sb.pop_front();
    tests++;
    if (get_sum(d) !== e.sum) begin
      fails++;
      $display("FAIL sum dut%0d a=%h b=%h cin=%b sub=%b: got %h, required %h", d, a, b, c, s, get_sum(d), e.sum);
    end
    tests++;
    if (get_co(d) !== e.cout) begin
      fails++;
      $display("FAIL cout dut%0d a=%h b=%h cin=%b sub=%b: got %b, required %b", d, a, b, c, s, get_co(d), e.cout);
    end
    tests++;
    if (get_of(d) !== e.ovf) begin
      fails++;
      $display("FAIL overflow dut%0d a=%h b=%h cin=%b sub=%b: got %b, required %b", d, a, b, c, s, get_of(d), e.ovf);
    end
    tests++;
    if (get_ir(d) !== 1'b0) begin
      fails++;
      $display("FAIL in_ready_in_done dut%0d: got %b, required 0", d, get_ir(d));
    end
    hs = e.sum; hc = e.cout; ho = e.ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iv[d] = i[0];
      tests++;
      if ({get_ov(d), get_sum(d), get_co(d), get_of(d), get_ir(d)} !== {1'b1, hs, hc, ho, 1'b0}) begin
        fails++;
        $display("FAIL hold dut%0d cycle %0d: ov=%b sum=%h co=%b of=%b ir=%b, required 1 %h %b %b 0",
                 d, i, get_ov(d), get_sum(d), get_co(d), get_of(d), get_ir(d), hs, hc, ho);
      end
    end
    iv[d] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({get_ir(d), get_ov(d)} !== 2'b10) begin
      fails++;
      $display("FAIL back_to_idle dut%0d: in_ready=%b out_valid=%b, required 1 0", d, get_ir(d), get_ov(d));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv = '0;
    out_ready = 1'b1;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({get_ir(d), get_ov(d), get_sum(d), get_co(d), get_of(d)} !== {2'b10, 16'h0000, 2'b00}) begin
        fails++;
        $display("FAIL reset dut%0d: ir=%b ov=%b sum=%h co=%b of=%b, required 1 0 0000 0 0",
                 d, get_ir(d), get_ov(d), get_sum(d), get_co(d), get_of(d));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_op(0, 16'h000F, 16'h0001, 1'b0, 1'b0, 0);
    do_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, 0);
    do_op(0, 16'h00FF, 16'h0001, 1'b1, 1'b0, 0);
  endtask

  task automatic test_sub();
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(0, 16'h0080, 16'h0001, 1'b0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    do_op(0, 16'h0080, 16'h0080, 1'b1, 1'b0, 5);
    do_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_run();
    int k;
    @(negedge clk);
    a_in = 16'h0055; b_in = 16'h0033; cin = 1'b1; sub = 1'b0;
    iv[0] = 1'b1;
    k = 0;
    while (!ir0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({ov0, ir0, sum0} !== {2'b01, 8'h00}) begin
      fails++;
      $display("FAIL reset_mid_run: ov=%b ir=%b sum=%h, required 0 1 00", ov0, ir0, sum0);
    end
    do_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 0);
  endtask

  task automatic test_sweep(input int d, input int n);
    do_op(d, 16'h007F, 16'h0001, 1'b0, 1'b0, 0);
    do_op(d, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    for (int i = 0; i < n; i++) begin
      do_op(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_sweep(1, 20);
    test_sweep(2, 20);
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
